// File: rtl/dvp_tx_pkg.sv
// dvp_tx_pkg: shared types and constants for the DVP transmitter.
//   dvp_state_e : frame sequencing phases (also exported as the timing phase)
//   HI_FIRST    : byte order on the DVP bus; 1 = RGB565 high byte first
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_V_BACK,
        ST_ACTIVE,
        ST_V_FRONT
    } dvp_state_e;

    localparam bit HI_FIRST = 1'b1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// dvp_timing_gen: line/frame counters and the frame sequencing FSM.
//   sys_clk, sys_rst : clock, async active-high reset
//   enable           : start/continue frames, looked at only at frame boundaries
//   phase            : current FSM state
//   h_cnt            : position inside the current line, 0..H_TOTAL-1
//   vsync            : registered frame sync
//   frame_done       : registered one-cycle pulse on the last clock of the frame
//   slot             : pixel slot strobe, high the cycle before each high-byte cycle
//
// state      | meaning
// ST_IDLE    | waiting for enable, counters held at 0
// ST_VSYNC   | VSYNC_LINES line periods with vsync high
// ST_V_BACK  | V_BACK blank line periods
// ST_ACTIVE  | V_ACTIVE lines, href during the first 2*H_ACTIVE clocks of each
// ST_V_FRONT | V_FRONT blank line periods, frame_done on the final clock
module dvp_timing_gen
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 64,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 8,
    parameter int V_FRONT     = 8,
    parameter int H_TOTAL     = 2 * H_ACTIVE + H_BLANK,
    parameter int H_W         = $clog2(H_TOTAL)
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           enable,
    output dvp_state_e     phase,
    output logic [H_W-1:0] h_cnt,
    output logic           vsync,
    output logic           frame_done,
    output logic           slot
);

    localparam int V_W = $clog2(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT) + 1);
    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    // Phase whose final clock ends the frame (V_FRONT may be configured away).
    localparam dvp_state_e LAST_PHASE = (V_FRONT > 0) ? ST_V_FRONT : ST_ACTIVE;

    dvp_state_e     state_q, state_d;
    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic           vsync_q, vsync_d;
    logic           frame_done_q, frame_done_d;
    logic           line_end, phase_end;

    function automatic logic last_line(input dvp_state_e s, input logic [V_W-1:0] v);
        case (s)
            ST_VSYNC:   return int'(v) == VSYNC_LINES - 1;
            ST_V_BACK:  return int'(v) == V_BACK - 1;
            ST_ACTIVE:  return int'(v) == V_ACTIVE - 1;
            ST_V_FRONT: return int'(v) == V_FRONT - 1;
            default:    return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        line_end  = (h_cnt_q == H_LAST);
        phase_end = line_end && last_line(state_q, v_cnt_q);

        if (state_q != ST_IDLE) begin
            h_cnt_d = line_end ? '0 : h_cnt_q + H_W'(1);
            if (line_end) v_cnt_d = phase_end ? '0 : v_cnt_q + V_W'(1);
        end

        case (state_q)
            ST_IDLE:    if (enable) state_d = ST_VSYNC;
            ST_VSYNC:   if (phase_end) state_d = (V_BACK > 0) ? ST_V_BACK : ST_ACTIVE;
            ST_V_BACK:  if (phase_end) state_d = ST_ACTIVE;
            ST_ACTIVE:  if (phase_end) state_d = (V_FRONT > 0) ? ST_V_FRONT :
                                                 (enable ? ST_VSYNC : ST_IDLE);
            ST_V_FRONT: if (phase_end) state_d = enable ? ST_VSYNC : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with state_q.
        vsync_d      = (state_d == ST_VSYNC);
        frame_done_d = (state_d == LAST_PHASE) && (h_cnt_d == H_LAST) &&
                       last_line(state_d, v_cnt_d);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            vsync_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            vsync_q      <= vsync_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Look-ahead: a slot opens when the next cycle is an even (high-byte) href position.
    assign slot       = (state_d == ST_ACTIVE) && (int'(h_cnt_d) < 2 * H_ACTIVE) && !h_cnt_d[0];
    assign phase      = state_q;
    assign h_cnt      = h_cnt_q;
    assign vsync      = vsync_q;
    assign frame_done = frame_done_q;

endmodule

// File: rtl/dvp_tx.sv
// dvp_tx: DVP (OV5640-style) transmitter, RGB565 stream in, vsync/href/8-bit out.
//   sys_clk, sys_rst : clock (forwarded as PCLK outside), async active-high reset
//   enable           : start/continue frames, looked at only at frame boundaries
//   pix_valid/ready  : pixel stream handshake, pix_data is RGB565
//   dvp_vsync        : frame sync, dvp_href: line valid, dvp_data: byte bus
//   frame_done       : one-cycle pulse on the last clock of V_FRONT
//   underflow        : sticky, a pixel slot found pix_valid low
module dvp_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 64,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 8,
    parameter int V_FRONT     = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        underflow
);

    localparam int H_TOTAL = 2 * H_ACTIVE + H_BLANK;
    localparam int H_W     = $clog2(H_TOTAL);

    dvp_state_e     phase;
    logic [H_W-1:0] h_cnt;
    logic           slot;
    logic [15:0]    pix_q, pix_d;
    logic           underflow_q, underflow_d;
    logic           first_byte;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .H_TOTAL     (H_TOTAL),
        .H_W         (H_W)
    ) u_timing (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .phase      (phase),
        .h_cnt      (h_cnt),
        .vsync      (dvp_vsync),
        .frame_done (frame_done),
        .slot       (slot)
    );

    always_comb begin
        pix_d       = pix_q;
        underflow_d = underflow_q;
        if (slot) begin
            // A missing pixel is sent as black; line timing never waits for upstream.
            pix_d = pix_valid ? pix_data : 16'h0000;
            if (!pix_valid) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pix_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            pix_q       <= pix_d;
            underflow_q <= underflow_d;
        end
    end

    assign dvp_href   = (phase == ST_ACTIVE) && (int'(h_cnt) < 2 * H_ACTIVE);
    assign first_byte = ~h_cnt[0];

    always_comb begin
        dvp_data = 8'h00;
        if (dvp_href) dvp_data = (first_byte == HI_FIRST) ? pix_q[15:8] : pix_q[7:0];
    end

    assign pix_ready = slot;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_dvp_tx.sv
// tb_dvp_tx: directed bench for dvp_tx with a 4x2 frame (H_TOTAL=11, 55 clocks/frame).
// Frame-relative cycle i: vsync 0..10, V_BACK 11..21, lines at 22..32 and 33..43
// (href on the first 8 clocks of each), V_FRONT 44..54, frame_done at 54.
module tb_dvp_tx;

    logic        sys_clk;
    logic        sys_rst;
    logic        enable;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        frame_done;
    logic        underflow;

    dvp_tx #(
        .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .dvp_vsync  (dvp_vsync),
        .dvp_href   (dvp_href),
        .dvp_data   (dvp_data),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tbl [0:15] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                16'h1357, 16'h2468, 16'hACE0, 16'hBDF1,
                                16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978,
                                16'h8796, 16'hA5B4, 16'hC3D2, 16'hE1F0};
    logic [15:0] exp_pix [0:7];

    int   src_idx   = 0;
    int   slot_no   = 0;
    int   drop_slot = -1;
    logic hs_prev   = 1'b0;
    logic slot_prev = 1'b0;

    logic       cap_vs    [0:127];
    logic       cap_href  [0:127];
    logic       cap_ready [0:127];
    logic       cap_fd    [0:127];
    logic       cap_uf    [0:127];
    logic [7:0] cap_data  [0:127];

    // One clock: advance the always-valid source after a handshake, drive inputs
    // on the falling edge, then sample outputs just after it.
    task automatic step();
        @(negedge sys_clk);
        if (slot_prev) begin
            if (hs_prev) src_idx++;
            slot_no++;
        end
        pix_data  = tbl[src_idx % 16];
        pix_valid = (slot_no != drop_slot);
        #1;
        hs_prev   = pix_ready && pix_valid;
        slot_prev = pix_ready;
    endtask

    task automatic capture(input int n, input int en_off_at);
        for (int i = 0; i < n; i++) begin
            if (i == en_off_at) enable = 1'b0;
            step();
            cap_vs[i]    = dvp_vsync;
            cap_href[i]  = dvp_href;
            cap_ready[i] = pix_ready;
            cap_fd[i]    = frame_done;
            cap_uf[i]    = underflow;
            cap_data[i]  = dvp_data;
        end
    endtask

    function automatic bit m_vs(input int i);
        return (i % 55) < 11;
    endfunction

    function automatic bit m_href(input int i);
        int j;
        j = i % 55;
        return (j >= 22) && (j < 44) && (((j - 22) % 11) < 8);
    endfunction

    function automatic bit m_ready(input int i);
        int j;
        j = (i + 1) % 55;
        return m_href(i + 1) && ((((j - 22) % 11) % 2) == 0);
    endfunction

    function automatic bit m_fd(input int i);
        return (i % 55) == 54;
    endfunction

    function automatic logic [7:0] m_byte(input int i);
        int j, line, h;
        logic [15:0] px;
        j = i % 55;
        if (!m_href(i)) return 8'h00;
        line = (j - 22) / 11;
        h    = (j - 22) % 11;
        px   = exp_pix[line * 4 + h / 2];
        return (h % 2 == 0) ? px[15:8] : px[7:0];
    endfunction

    task automatic test_reset();
        sys_rst = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_data = 16'h0;
        repeat (3) @(negedge sys_clk);
        n_checks++; if (dvp_vsync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync got=%b exp=0", dvp_vsync); end
        n_checks++; if (dvp_href !== 1'b0) begin n_fail++; $display("FAIL reset_href got=%b exp=0", dvp_href); end
        n_checks++; if (dvp_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", dvp_data); end
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", pix_ready); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        enable  = 1'b1;
        sys_rst = 1'b0;
    endtask

    task automatic test_frame();
        for (int k = 0; k < 8; k++) exp_pix[k] = tbl[k];
        capture(110, -1);
        for (int i = 0; i < 56; i++) begin
            n_checks++; if (cap_vs[i] !== m_vs(i)) begin n_fail++; $display("FAIL frame_vsync cyc=%0d got=%b exp=%b", i, cap_vs[i], m_vs(i)); end
            n_checks++; if (cap_href[i] !== m_href(i)) begin n_fail++; $display("FAIL frame_href cyc=%0d got=%b exp=%b", i, cap_href[i], m_href(i)); end
            n_checks++; if (cap_ready[i] !== m_ready(i)) begin n_fail++; $display("FAIL frame_ready cyc=%0d got=%b exp=%b", i, cap_ready[i], m_ready(i)); end
            n_checks++; if (cap_fd[i] !== m_fd(i)) begin n_fail++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", i, cap_fd[i], m_fd(i)); end
            n_checks++; if (cap_data[i] !== m_byte(i)) begin n_fail++; $display("FAIL frame_data cyc=%0d got=%h exp=%h", i, cap_data[i], m_byte(i)); end
            n_checks++; if (cap_vs[i] && cap_href[i]) begin n_fail++; $display("FAIL frame_vs_href_overlap cyc=%0d got=1 exp=0", i); end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) exp_pix[k] = tbl[8 + k];
        for (int i = 55; i < 110; i++) begin
            n_checks++; if (cap_vs[i] !== m_vs(i)) begin n_fail++; $display("FAIL b2b_vsync cyc=%0d got=%b exp=%b", i, cap_vs[i], m_vs(i)); end
            n_checks++; if (cap_href[i] !== m_href(i)) begin n_fail++; $display("FAIL b2b_href cyc=%0d got=%b exp=%b", i, cap_href[i], m_href(i)); end
            n_checks++; if (cap_data[i] !== m_byte(i)) begin n_fail++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, cap_data[i], m_byte(i)); end
            n_checks++; if (cap_fd[i] !== m_fd(i)) begin n_fail++; $display("FAIL b2b_frame_done cyc=%0d got=%b exp=%b", i, cap_fd[i], m_fd(i)); end
        end
    endtask

    task automatic test_handshake();
        int pulses;
        int uf_seen;
        pulses = 0; uf_seen = 0;
        for (int i = 55; i < 110; i++) begin
            if (cap_ready[i]) begin
                pulses++;
                n_checks++;
                if (!(cap_href[i + 1] && !cap_href[i] || cap_href[i + 1] && cap_href[i - 1] && cap_href[i])) begin
                    n_fail++; $display("FAIL hs_ready_position cyc=%0d got=no_href_next exp=even_href_next", i);
                end
            end
            if (cap_uf[i]) uf_seen++;
        end
        n_checks++; if (pulses != 8) begin n_fail++; $display("FAIL hs_pulse_count got=%0d exp=8", pulses); end
        n_checks++; if (uf_seen != 0) begin n_fail++; $display("FAIL hs_underflow_cycles got=%0d exp=0", uf_seen); end
    endtask

    task automatic test_underflow();
        drop_slot = slot_no + 2;
        exp_pix[0] = tbl[0]; exp_pix[1] = tbl[1]; exp_pix[2] = 16'h0000;
        for (int k = 3; k < 8; k++) exp_pix[k] = tbl[k - 1];
        capture(110, -1);
        for (int i = 0; i < 55; i++) begin
            n_checks++; if (cap_href[i] !== m_href(i)) begin n_fail++; $display("FAIL uf_href cyc=%0d got=%b exp=%b", i, cap_href[i], m_href(i)); end
            n_checks++; if (cap_data[i] !== m_byte(i)) begin n_fail++; $display("FAIL uf_data cyc=%0d got=%h exp=%h", i, cap_data[i], m_byte(i)); end
            n_checks++; if (cap_uf[i] !== (i >= 26)) begin n_fail++; $display("FAIL uf_flag cyc=%0d got=%b exp=%b", i, cap_uf[i], (i >= 26)); end
        end
        for (int i = 55; i < 110; i++) begin
            n_checks++; if (cap_uf[i] !== 1'b1) begin n_fail++; $display("FAIL uf_sticky cyc=%0d got=%b exp=1", i, cap_uf[i]); end
            n_checks++; if (cap_href[i] !== m_href(i)) begin n_fail++; $display("FAIL uf_next_href cyc=%0d got=%b exp=%b", i, cap_href[i], m_href(i)); end
        end
    endtask

    task automatic test_enable_drop();
        capture(60, 35);
        for (int i = 0; i < 55; i++) begin
            n_checks++; if (cap_href[i] !== m_href(i)) begin n_fail++; $display("FAIL endrop_href cyc=%0d got=%b exp=%b", i, cap_href[i], m_href(i)); end
            n_checks++; if (cap_fd[i] !== m_fd(i)) begin n_fail++; $display("FAIL endrop_frame_done cyc=%0d got=%b exp=%b", i, cap_fd[i], m_fd(i)); end
        end
        for (int i = 55; i < 60; i++) begin
            n_checks++; if ({cap_vs[i], cap_href[i], cap_ready[i], cap_fd[i], cap_data[i]} !== 12'h000) begin
                n_fail++; $display("FAIL endrop_idle cyc=%0d got=%b%b%b%b_%h exp=0000_00", i, cap_vs[i], cap_href[i], cap_ready[i], cap_fd[i], cap_data[i]);
            end
            n_checks++; if (cap_uf[i] !== 1'b1) begin n_fail++; $display("FAIL endrop_uf_held cyc=%0d got=%b exp=1", i, cap_uf[i]); end
        end
        enable = 1'b1;
        step();
        n_checks++; if (dvp_vsync !== 1'b1) begin n_fail++; $display("FAIL reenable_vsync got=%b exp=1", dvp_vsync); end
    endtask

    task automatic test_reset_mid();
        repeat (22) step();
        n_checks++; if (dvp_href !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_href got=%b exp=1", dvp_href); end
        #2 sys_rst = 1'b1;
        #1;
        n_checks++; if (dvp_href !== 1'b0) begin n_fail++; $display("FAIL rstmid_href got=%b exp=0", dvp_href); end
        n_checks++; if (dvp_vsync !== 1'b0) begin n_fail++; $display("FAIL rstmid_vsync got=%b exp=0", dvp_vsync); end
        n_checks++; if (dvp_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got=%h exp=00", dvp_data); end
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=0", pix_ready); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_underflow got=%b exp=0", underflow); end
        repeat (3) step();
        src_idx = 0; slot_no = 0; drop_slot = -1; hs_prev = 1'b0; slot_prev = 1'b0;
        sys_rst = 1'b0;
        for (int k = 0; k < 8; k++) exp_pix[k] = tbl[k];
        capture(55, -1);
        for (int i = 0; i < 55; i++) begin
            n_checks++; if (cap_vs[i] !== m_vs(i)) begin n_fail++; $display("FAIL rstmid_frame_vsync cyc=%0d got=%b exp=%b", i, cap_vs[i], m_vs(i)); end
            n_checks++; if (cap_data[i] !== m_byte(i)) begin n_fail++; $display("FAIL rstmid_frame_data cyc=%0d got=%h exp=%h", i, cap_data[i], m_byte(i)); end
            n_checks++; if (cap_fd[i] !== m_fd(i)) begin n_fail++; $display("FAIL rstmid_frame_done cyc=%0d got=%b exp=%b", i, cap_fd[i], m_fd(i)); end
            n_checks++; if (cap_uf[i] !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_uf cyc=%0d got=%b exp=0", i, cap_uf[i]); end
        end
    endtask

    // Receiver-side reassembly: pair consecutive href bytes into 16-bit words.
    task automatic test_loopback();
        int nw;
        logic have_hi;
        logic [7:0] hi;
        logic [15:0] word;
        nw = 0; have_hi = 1'b0; hi = 8'h00;
        capture(55, -1);
        for (int i = 0; i < 55; i++) begin
            if (cap_href[i]) begin
                if (have_hi) begin
                    word = {hi, cap_data[i]};
                    n_checks++;
                    if (nw < 8 && word !== tbl[8 + nw]) begin
                        n_fail++; $display("FAIL loopback_word idx=%0d got=%h exp=%h", nw, word, tbl[8 + nw]);
                    end
                    nw++;
                    have_hi = 1'b0;
                end else begin
                    hi = cap_data[i];
                    have_hi = 1'b1;
                end
            end
        end
        n_checks++; if (nw != 8) begin n_fail++; $display("FAIL loopback_word_count got=%0d exp=8", nw); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_handshake();
        test_underflow();
        test_enable_drop();
        test_reset_mid();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
